// File: rtl/tdc_pkg.sv
// Shared constants and FSM state type for the time-to-digital converter.
package tdc_pkg;

  localparam int unsigned PHASES   = 32;
  localparam int unsigned FINE_W   = 5;
  localparam int unsigned COARSE_W = 8;
  localparam int unsigned TOF_W    = COARSE_W + FINE_W;

  localparam logic [TOF_W-1:0]    TOF_OVF     = {TOF_W{1'b1}};
  // Last in-range coarse value; the next count without a stop is an overflow.
  localparam logic [COARSE_W-1:0] COARSE_LAST = {{(COARSE_W-1){1'b1}}, 1'b0};

  typedef enum logic [0:0] {
    StIdle,
    StCount
  } state_t;

endpackage

// File: rtl/tdc_therm_decode.sv
// Rotating thermometer-code decoder: returns the index of the 0->1 transition.
// With TDC_FINE_EN undefined the decode is dropped and fine is tied to zero.
module tdc_therm_decode
  import tdc_pkg::*;
(
  input  logic [PHASES-1:0] phase,
  output logic [FINE_W-1:0] fine
);

`ifdef TDC_FINE_EN
  // All-0 and all-1 snapshots have no transition and fall through to zero.
  always_comb begin
    fine = '0;
    for (int i = 0; i < PHASES; i++) begin
      if (phase[i] && !phase[(i + PHASES - 1) % PHASES]) begin
        fine = FINE_W'(i);
      end
    end
  end
`else
  logic unused_phase;
  assign unused_phase = ^phase;
  assign fine         = '0;
`endif

endmodule

// File: rtl/tdc_top.sv
// Time-to-digital converter: coarse clk count plus fine phase interpolation.
// Fine interpolation is enabled by defining TDC_FINE_EN.
module tdc_top
  import tdc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [PHASES-1:0] phase,
  input  logic              start,
  input  logic              light_pulse,
  output logic [TOF_W-1:0]  tof,
  output logic              out_valid
);

  logic [2:0]          start_sync_q, stop_sync_q;
  logic                start_stb_q, stop_stb_q;
  logic [PHASES-1:0]   phase_q;
  logic [FINE_W-1:0]   cur_fine;
  logic [FINE_W-1:0]   start_fine_q;
  logic [COARSE_W-1:0] coarse_q;
  logic [COARSE_W-1:0] elapsed;
  logic [TOF_W-1:0]    stop_tof;
  logic [TOF_W-1:0]    tof_q;
  logic                out_valid_q;
  state_t              state_q;

  // Phase is captured on the same edge as the strobes so each strobe sees its own snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_sync_q <= '0;
      stop_sync_q  <= '0;
      start_stb_q  <= 1'b0;
      stop_stb_q   <= 1'b0;
      phase_q      <= '0;
    end else begin
      start_sync_q <= {start_sync_q[1:0], start};
      stop_sync_q  <= {stop_sync_q[1:0], light_pulse};
      start_stb_q  <= start_sync_q[1] & ~start_sync_q[2];
      stop_stb_q   <= stop_sync_q[1] & ~stop_sync_q[2];
      phase_q      <= phase;
    end
  end

  tdc_therm_decode u_decode (
    .phase (phase_q),
    .fine  (cur_fine)
  );

  // The stop edge itself is one of the counted clk edges.
  assign elapsed  = coarse_q + 1'b1;
  assign stop_tof = {elapsed, {FINE_W{1'b0}}} + {{COARSE_W{1'b0}}, cur_fine}
                  - {{COARSE_W{1'b0}}, start_fine_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      coarse_q     <= '0;
      start_fine_q <= '0;
      tof_q        <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_stb_q) begin
            coarse_q     <= '0;
            start_fine_q <= cur_fine;
            state_q      <= StCount;
          end
        end
        StCount: begin
          if (start_stb_q) begin
            coarse_q     <= '0;
            start_fine_q <= cur_fine;
          end else if (stop_stb_q) begin
            tof_q       <= stop_tof;
            out_valid_q <= 1'b1;
            state_q     <= StIdle;
          end else if (coarse_q == COARSE_LAST) begin
            coarse_q    <= elapsed;
            tof_q       <= TOF_OVF;
            out_valid_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            coarse_q <= elapsed;
          end
        end
      endcase
    end
  end

  assign tof       = tof_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_tdc_top.sv
// Scoreboard bench for tdc_top: stimulus pushes expected tof, a monitor pops on out_valid.
module tb_tdc_top;

`ifdef TDC_FINE_EN
  localparam bit FineEn = 1'b1;
`else
  localparam bit FineEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] phase = '0;
  logic        start = 1'b0;
  logic        light_pulse = 1'b0;
  logic [12:0] tof;
  logic        out_valid;

  logic [12:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        prev_valid = 1'b0;

  tdc_top dut (
    .clk         (clk),
    .rst         (rst),
    .phase       (phase),
    .start       (start),
    .light_pulse (light_pulse),
    .tof         (tof),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Monitor: every out_valid pulse must match the head of the scoreboard.
  initial begin
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (rst && out_valid) begin
        checks++;
        if (prev_valid) begin
          errors++;
          $display("FAIL valid_width: out_valid high two cycles in a row, tof=%0d", tof);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got tof=%0d, expected no output", tof);
        end else begin
          e = exp_q.pop_front();
          if (tof !== e) begin
            errors++;
            $display("FAIL tof_value: got %0d, expected %0d", tof, e);
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d result(s) missing after %0d cycles, expected 0", name,
               exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic measure(input logic [31:0] ps, input logic [31:0] pe, input int gap,
                         input logic [12:0] want, input string name);
    phase = ps;
    start = 1'b1;
    exp_q.push_back(want);
    tick(gap);
    phase = pe;
    light_pulse = 1'b1;
    tick(6);
    start = 1'b0;
    light_pulse = 1'b0;
    tick(4);
    drain(name, 40);
  endtask

  initial begin
    tick(3);
    check("reset_tof", tof, 13'd0);
    check("reset_valid", {12'd0, out_valid}, 13'd0);
    rst = 1'b1;
    tick(20);

    // Constant phase: fine terms cancel, 110 edges -> 110*32.
    measure(32'hFFFF0000, 32'hFFFF0000, 110, 13'd3520, "tof_110");
    light_pulse = 1'b1;
    tick(3);
    light_pulse = 1'b0;
    tick(10);
    check("second_stop_ignored", tof, 13'd3520);

    // fine 16 -> 20 over 10 edges
    measure(32'hFFFF0000, 32'hFFF0000F, 10, FineEn ? 13'd324 : 13'd320, "tof_fine_up");
    // fine 20 -> 4 over 7 edges
    measure(32'hFFF0000F, 32'h000FFFF0, 7, FineEn ? 13'd208 : 13'd224, "tof_fine_down");
    // all-ones start snapshot decodes as fine 0; stop fine 16 over 3 edges
    measure(32'hFFFFFFFF, 32'hFFFF0000, 3, FineEn ? 13'd112 : 13'd96, "tof_all_ones");

    // Second start 8 cycles after the first restarts; stop 6 edges later.
    phase = 32'h00FFFF00;
    start = 1'b1;
    tick(4);
    start = 1'b0;
    tick(4);
    start = 1'b1;
    exp_q.push_back(13'd192);
    tick(6);
    light_pulse = 1'b1;
    tick(6);
    start = 1'b0;
    light_pulse = 1'b0;
    tick(4);
    drain("restart", 40);

    // Stop without a start produces nothing.
    light_pulse = 1'b1;
    tick(4);
    light_pulse = 1'b0;
    tick(20);
    check("stop_no_start_hold", tof, 13'd192);

    // No stop: overflow word after 255 counts, then back in idle.
    start = 1'b1;
    exp_q.push_back(13'd8191);
    tick(4);
    start = 1'b0;
    drain("overflow", 300);
    light_pulse = 1'b1;
    tick(4);
    light_pulse = 1'b0;
    tick(10);
    check("overflow_hold", tof, 13'd8191);

    // Reset 30 clk into a measurement aborts it.
    start = 1'b1;
    tick(4);
    start = 1'b0;
    tick(26);
    rst = 1'b0;
    tick(2);
    check("midreset_tof", tof, 13'd0);
    check("midreset_valid", {12'd0, out_valid}, 13'd0);
    rst = 1'b1;
    tick(2);
    light_pulse = 1'b1;
    tick(4);
    light_pulse = 1'b0;
    tick(20);
    check("after_reset_stop", tof, 13'd0);

    measure(32'h00FFFF00, 32'h00FFFF00, 5, 13'd160, "tof_5");

    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdc_top.md
Name: tdc_top

Overview:
Time-to-digital converter measuring the interval between a start event and the first subsequent light_pulse (stop) event. Coarse time counts clk cycles; fine time comes from decoding a 32-tap thermometer-coded phase snapshot at each event. It sits between the laser-fire control (start) and the photodetector front end (light_pulse), and delivers one 13-bit time-of-flight word per measurement.

Parameters:
- PHASES, 32, number of phase taps; fine field is log2(PHASES) = 5 bits.
- COARSE_W, 8, coarse counter width.
- TOF_W, 13, output width, equal to COARSE_W + 5.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- phase  input  32  multiphase snapshot, thermometer code (16 contiguous ones, rotating).
- start  input  1  asynchronous start request; the rising edge begins a measurement.
- light_pulse  input  1  asynchronous stop; the rising edge ends a measurement.
- tof  output  13  measured time in units of clk_period/32.
- out_valid  output  1  single-cycle strobe; tof is valid in the same cycle.

Behaviour:
- Reset (rst=0, async): state IDLE, coarse=0, tof=0, out_valid=0, synchronisers cleared.
- start and light_pulse each pass through a 2-flop synchroniser, then a registered rising-edge detector, giving an edge strobe 3 clk after the input edge. Equal latency on both paths, so it cancels in the result.
- Fine decode: fine = index i where phase[i]=1 and phase[(i-1) mod 32]=0.
  - Example: 0xFFFF0000 gives fine=16.
  - If phase is all-0 or all-1, fine=0.
  - phase is registered on the same clk edge as the event strobe.
- FSM:
  - IDLE: start strobe → coarse<=0, latch start_fine, go to COUNT. light_pulse strobe is ignored.
  - COUNT: coarse increments every clk.
    - Stop strobe → tof <= {coarse,5'b0} + stop_fine − start_fine (mod 2^13), out_valid=1 next cycle, return to IDLE.
    - Start strobe → restart (coarse<=0, relatch start_fine), no output.
    - Start and stop strobes in the same cycle → start wins (restart).
    - Overflow: coarse reaches 255 without a stop → tof=13'h1FFF, out_valid pulse, go to IDLE.
- Coarse value equals the number of clk edges between the start strobe and the stop strobe.
- out_valid is high for exactly one cycle. tof holds its value until the next result or reset.
- A held-high light_pulse produces only one edge. Further stops in IDLE are ignored.
- Reset mid-COUNT aborts the measurement with no out_valid.

Optional Feature:
- Macro TDC_FINE_EN.
  - Defined: fine decode and subtraction as above.
  - Undefined: decoder removed and fine terms forced to 0, so tof = {coarse,5'b0}. Overflow value is unchanged.

Decomposition:
- tdc_pkg holds:
  - constants PHASES=32, FINE_W=5, COARSE_W=8, TOF_W=13, TOF_OVF=13'h1FFF;
  - typedef state_t {IDLE, COUNT}.
- One sub-module: tdc_therm_decode (32-bit thermometer in, 5-bit fine out, combinational).
- Synchronisers and edge detectors are inline.

Test Plan:
- Reset: assert rst=0 mid-stream → tof=0, out_valid=0. Release; idle 20 cycles → out_valid stays 0.
- phase held 0xFFFF0000; start rises; light_pulse rises 110 clk later → one out_valid pulse, tof=3520.
- phase=0xFFFF0000 at start (fine 16), phase=0xFFF0000F at stop (fine 20), stop 10 clk after start → tof=324.
- light_pulse pulse with no preceding start → no out_valid. Second stop right after a completed measurement → ignored, tof unchanged.
- start with no stop → after 255 counts, out_valid pulse with tof=8191, FSM returns to IDLE.
- Reset asserted 30 clk after start, then stop issued → no out_valid, tof=0. A new start/stop 5 clk apart with constant phase → tof=160.
